// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dm_pkg
// Description : Shared constants and types for the dual-port data-memory
//               arbiter: access-size encodings, FSM state type, port count.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

  // Number of requester ports handled by the arbiter
  localparam int NREQ = 2;

  // Access size encodings presented on size_i
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } dm_state_e;

endpackage
`default_nettype wire

// File: rtl/dm_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module      : dm_lane_fmt
// Description : Combinational byte-lane formatter: byte-enable generation,
//               alignment check and load-data extract/extend.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_lane_fmt (
  input  logic [1:0]  i_off,      // byte offset within the word
  input  logic [1:0]  i_size,     // access size encoding
  input  logic        i_sext,     // sign-extend sub-word loads
  input  logic [31:0] i_dout,     // raw memory word
  output logic [3:0]  o_be,       // byte enables (zero when misaligned)
  output logic        o_misalign, // misaligned or illegal size
  output logic [31:0] o_ldata     // right-aligned, extended load data
);
  import dm_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Alignment check: halves need even offset, words need offset 0
  always_comb begin
    o_misalign = 1'b0;
    case (i_size)
      SZ_BYTE: o_misalign = 1'b0;
      SZ_HALF: o_misalign = i_off[0];
      SZ_WORD: o_misalign = (i_off != 2'b00);
      default: o_misalign = 1'b1;
    endcase
  end

  // Byte enables; a rejected access never enables any lane
  always_comb begin
    o_be = 4'b0000;
    if (!o_misalign) begin
      case (i_size)
        SZ_BYTE: o_be = 4'b0001 << i_off;
        SZ_HALF: o_be = i_off[1] ? 4'b1100 : 4'b0011;
        SZ_WORD: o_be = 4'b1111;
        default: o_be = 4'b0000;
      endcase
    end
  end

  // Lane select for sub-word loads
  always_comb begin
    w_byte = i_dout[7:0];
    case (i_off)
      2'd0:    w_byte = i_dout[7:0];
      2'd1:    w_byte = i_dout[15:8];
      2'd2:    w_byte = i_dout[23:16];
      default: w_byte = i_dout[31:24];
    endcase
    w_half = i_off[1] ? i_dout[31:16] : i_dout[15:0];
  end

  // Right-align and extend the selected lane
  always_comb begin
    o_ldata = 32'h0000_0000;
    if (!o_misalign) begin
      case (i_size)
        SZ_BYTE: o_ldata = {{24{i_sext & w_byte[7]}}, w_byte};
        SZ_HALF: o_ldata = {{16{i_sext & w_half[15]}}, w_half};
        SZ_WORD: o_ldata = i_dout;
        default: o_ldata = 32'h0000_0000;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter
// Description : Round-robin arbiter granting two requesters access to a
//               single-port data memory; IDLE -> ACCESS -> DONE sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
  parameter int NREQ = dm_pkg::NREQ,
  parameter int AW   = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ-1:0]           we_i,
  input  logic [NREQ-1:0][AW-1:0]   addr_i,
  input  logic [NREQ-1:0][1:0]      size_i,
  input  logic [NREQ-1:0]           sext_i,
  input  logic [NREQ-1:0][31:0]     wdata_i,
  output logic [NREQ-1:0]           ack_o,
  output logic [NREQ-1:0]           err_o,
  output logic [31:0]               rdata_o,
  output logic                      mem_we,
  output logic [AW-3:0]             mem_addr,
  output logic [3:0]                mem_be,
  output logic [31:0]               mem_din,
  input  logic [31:0]               mem_dout
);
  import dm_pkg::*;

  dm_state_e     r_state;
  logic          r_gnt;    // port owning the current access
  logic          r_last;   // port granted most recently
  logic          r_we;
  logic          r_sext;
  logic          r_err;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_size;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;

  logic          w_sel;
  logic [1:0]    w_fmt_off;
  logic [1:0]    w_fmt_size;
  logic          w_fmt_sext;
  logic [3:0]    w_be;
  logic          w_mis;
  logic [31:0]   w_ldata;

  // Round-robin pick: on contention favour the port not granted last
  always_comb begin
    w_sel = 1'b0;
    if (req_i[0] && req_i[1]) begin
      w_sel = ~r_last;
    end else if (req_i[1]) begin
      w_sel = 1'b1;
    end
  end

  // The formatter checks the incoming request in IDLE and the latched one later
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_fmt_off  = addr_i[w_sel][1:0];
      w_fmt_size = size_i[w_sel];
      w_fmt_sext = sext_i[w_sel];
    end else begin
      w_fmt_off  = r_addr[1:0];
      w_fmt_size = r_size;
      w_fmt_sext = r_sext;
    end
  end

  dm_lane_fmt u_lane_fmt (
    .i_off      (w_fmt_off),
    .i_size     (w_fmt_size),
    .i_sext     (w_fmt_sext),
    .i_dout     (mem_dout),
    .o_be       (w_be),
    .o_misalign (w_mis),
    .o_ldata    (w_ldata)
  );

  // Grant, latch the winner's fields, run the access, then report completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_size  <= 2'b00;
      r_wdata <= 32'h0000_0000;
      r_rdata <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_i) begin
            r_gnt   <= w_sel;
            r_last  <= w_sel;
            r_we    <= we_i[w_sel];
            r_addr  <= addr_i[w_sel];
            r_size  <= size_i[w_sel];
            r_sext  <= sext_i[w_sel];
            r_wdata <= wdata_i[w_sel];
            r_err   <= w_mis;
            r_rdata <= 32'h0000_0000;
            // A rejected access skips the memory cycle entirely
            r_state <= w_mis ? ST_DONE : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_rdata <= r_we ? 32'h0000_0000 : w_ldata;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory strobes exist only in ACCESS so a reset drops them at once
  assign mem_we   = (r_state == ST_ACCESS) && r_we;
  assign mem_be   = (r_state == ST_ACCESS) ? w_be : 4'b0000;
  assign mem_addr = r_addr[AW-1:2];
  assign mem_din  = r_wdata;
  assign rdata_o  = r_rdata;

  for (genvar n = 0; n < NREQ; n++) begin : g_port
    assign ack_o[n] = (r_state == ST_DONE) && (r_gnt == 1'(n));
    assign err_o[n] = (r_state == ST_DONE) && (r_gnt == 1'(n)) && r_err;
  end

endmodule
`default_nettype wire
